// File: rtl/soc_ahb4_pkg.sv
// Shared AHB4-Lite encodings and the external responder FSM state type.
package soc_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8    = 3'b000;
    localparam logic [2:0] HSIZE_B16   = 3'b001;
    localparam logic [2:0] HSIZE_B32   = 3'b010;
    localparam logic [2:0] HSIZE_B64   = 3'b011;
    localparam logic [2:0] HSIZE_B128  = 3'b100;
    localparam logic [2:0] HSIZE_B256  = 3'b101;
    localparam logic [2:0] HSIZE_B512  = 3'b110;
    localparam logic [2:0] HSIZE_B1024 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } resp_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mpsoc_ahb4_ext_ram.sv
// Single-port backing store with per-byte write enables and asynchronous read.
module mpsoc_ahb4_ext_ram #(
    parameter int unsigned Depth = 1024,
    parameter int unsigned Width = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [Width/8-1:0]       be_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(Width / 8); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mpsoc_ahb4_ext_responder.sv
// AHB4-Lite slave backed by RAM, with programmable wait states, an error-injection
// window and saturating per-type transaction counters.
module mpsoc_ahb4_ext_responder
    import soc_ahb4_pkg::*;
#(
    parameter int unsigned     PLEN        = 32,
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     MEM_DEPTH   = 1024,
    parameter logic [PLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     WAIT_STATES = 0,
    parameter logic [PLEN-1:0] ERR_BASE    = PLEN'(32'hFFFF_F000),
    parameter int unsigned     ERR_SIZE    = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ahb4_hsel_i,
    input  logic [PLEN-1:0] ahb4_haddr_i,
    input  logic [XLEN-1:0] ahb4_hwdata_i,
    input  logic            ahb4_hwrite_i,
    input  logic [2:0]      ahb4_hsize_i,
    input  logic [2:0]      ahb4_hburst_i,
    input  logic [3:0]      ahb4_hprot_i,
    input  logic [1:0]      ahb4_htrans_i,
    input  logic            ahb4_hmastlock_i,
    input  logic            ahb4_hready_in_i,
    output logic [XLEN-1:0] ahb4_hrdata_o,
    output logic            ahb4_hready_o,
    output logic            ahb4_hresp_o,
    output logic [31:0]     rd_cnt_o,
    output logic [31:0]     wr_cnt_o,
    output logic [31:0]     err_cnt_o
);

    localparam int unsigned     NumBytes = XLEN / 8;
    localparam int unsigned     ByteAw   = $clog2(NumBytes);
    localparam int unsigned     WordAw   = $clog2(MEM_DEPTH);
    localparam logic [PLEN-1:0] MemBytes = PLEN'(MEM_DEPTH * NumBytes);
    localparam logic [PLEN-1:0] ErrSize  = PLEN'(ERR_SIZE);
    localparam logic [3:0]      WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_e     state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [PLEN-1:0] addr_q;
    logic [2:0]      size_q;
    logic            write_q;
    logic [XLEN-1:0] hrdata_q;
    logic [31:0]     rd_cnt_q, wr_cnt_q, err_cnt_q;

    logic            accept, load, addr_err, in_win;
    logic [PLEN-1:0] off_a, err_off, align_mask, off_q;
    logic [NumBytes-1:0] be;
    logic [XLEN-1:0] ram_rdata;
    logic            data_wr, data_rd;

    assign accept = ahb4_hsel_i & ahb4_hready_in_i &
                    ((ahb4_htrans_i == HTRANS_NONSEQ) | (ahb4_htrans_i == HTRANS_SEQ));

    // Address-phase error decode; an address below BASE_ADDR wraps and lands out of range.
    always_comb begin
        off_a      = ahb4_haddr_i - BASE_ADDR;
        err_off    = ahb4_haddr_i - ERR_BASE;
        align_mask = (PLEN'(1) << ahb4_hsize_i) - PLEN'(1);
        in_win     = (ERR_SIZE != 0) && (ahb4_haddr_i >= ERR_BASE) && (err_off < ErrSize);
        addr_err   = in_win || (off_a >= MemBytes) || (ahb4_hsize_i > 3'(ByteAw)) ||
                     ((ahb4_haddr_i & align_mask) != '0);
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        load          = 1'b0;
        ahb4_hready_o = 1'b1;
        ahb4_hresp_o  = HRESP_OKAY;
        case (state_q)
            StWait: begin
                ahb4_hready_o = 1'b0;
                if (wcnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            StErr1: begin
                ahb4_hready_o = 1'b0;
                ahb4_hresp_o  = HRESP_ERROR;
                state_d       = StErr2;
            end
            default: begin
                // IDLE, DATA and ERR2 all drive hready high, so a new address phase may land here.
                if (state_q == StErr2) begin
                    ahb4_hresp_o = HRESP_ERROR;
                end
                state_d = StIdle;
                if (accept) begin
                    load   = 1'b1;
                    wcnt_d = WaitInit;
                    if (addr_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_comb begin
        off_q = addr_q - BASE_ADDR;
        be    = '0;
        for (int i = 0; i < int'(NumBytes); i++) begin
            if (i >= int'(addr_q[ByteAw-1:0]) && i < int'(addr_q[ByteAw-1:0]) + (1 << size_q)) begin
                be[i] = 1'b1;
            end
        end
    end

    assign data_wr       = (state_q == StData) & write_q;
    assign data_rd       = (state_q == StData) & ~write_q;
    assign ahb4_hrdata_o = data_rd ? ram_rdata : hrdata_q;

    mpsoc_ahb4_ext_ram #(
        .Depth(MEM_DEPTH),
        .Width(XLEN)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (data_wr),
        .be_i   (be),
        .addr_i (off_q[ByteAw +: WordAw]),
        .wdata_i(ahb4_hwdata_i),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            wcnt_q    <= 4'd0;
            addr_q    <= '0;
            size_q    <= 3'd0;
            write_q   <= 1'b0;
            hrdata_q  <= '0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            err_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (load) begin
                addr_q  <= ahb4_haddr_i;
                size_q  <= ahb4_hsize_i;
                write_q <= ahb4_hwrite_i;
            end
            if (data_rd) begin
                hrdata_q <= ram_rdata;
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (data_wr) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
            if (state_q == StErr2) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign err_cnt_o = err_cnt_q;

    logic unused_ok;
    assign unused_ok = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i, off_q};

endmodule

// File: tb/tb_mpsoc_ahb4_ext_responder.sv
// Scoreboard bench: three responders (0, 3 and 5 wait states) on one driven bus, one selected at a time.
module tb_mpsoc_ahb4_ext_responder;

    localparam int unsigned MemDepth = 128;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [1:0]  sel;
    logic        hready_bus;

    logic [31:0] hrdata_w [3];
    logic        hready_w [3];
    logic        hresp_w  [3];
    logic [31:0] rd_w [3], wr_w [3], err_w [3];

    int          checks = 0;
    int          failures = 0;
    exp_t        sb [$];
    logic [7:0]  mdl [int];
    int          exp_rd [3], exp_wr [3], exp_err [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mpsoc_ahb4_ext_responder #(
            .MEM_DEPTH  (MemDepth),
            .BASE_ADDR  (32'h0),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5)),
            .ERR_BASE   (32'h100),
            .ERR_SIZE   (32'h10)
        ) u_dut (
            .clk_i           (clk),
            .rst_ni          (rst_n),
            .ahb4_hsel_i     (hsel && (sel == 2'(g))),
            .ahb4_haddr_i    (haddr),
            .ahb4_hwdata_i   (hwdata),
            .ahb4_hwrite_i   (hwrite),
            .ahb4_hsize_i    (hsize),
            .ahb4_hburst_i   (3'b000),
            .ahb4_hprot_i    (4'b0011),
            .ahb4_htrans_i   (htrans),
            .ahb4_hmastlock_i(1'b0),
            .ahb4_hready_in_i(hready_bus),
            .ahb4_hrdata_o   (hrdata_w[g]),
            .ahb4_hready_o   (hready_w[g]),
            .ahb4_hresp_o    (hresp_w[g]),
            .rd_cnt_o        (rd_w[g]),
            .wr_cnt_o        (wr_w[g]),
            .err_cnt_o       (err_w[g])
        );
    end

    assign hready_bus = hready_w[sel];

    function automatic int waits_of(input logic [1:0] k);
        return (k == 2'd0) ? 0 : ((k == 2'd1) ? 3 : 5);
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] m;
        m = (32'd1 << s) - 32'd1;
        return (a >= 32'h100 && a < 32'h110) || (a >= MemDepth * 4) || (s > 3'd2) ||
               ((a & m) != 32'd0);
    endfunction

    function automatic xfer_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                                 input logic [31:0] d);
        xfer_t x;
        x.wr = w; x.addr = a; x.size = s; x.wdata = d;
        return x;
    endfunction

    task automatic push_expected(input xfer_t x);
        exp_t e;
        int   base, lo, n;
        logic known;
        e.wr    = x.wr;
        e.err   = model_err(x.addr, x.size);
        e.chk   = 1'b0;
        e.rdata = 32'h0;
        e.waits = e.err ? 1 : waits_of(sel);
        base    = int'(sel) * 65536 + int'(x.addr & 32'hFFFF_FFFC);
        lo      = int'(x.addr[1:0]);
        n       = 1 << x.size;
        if (e.err) begin
            exp_err[sel]++;
        end else if (x.wr) begin
            for (int b = lo; b < lo + n; b++) mdl[base + b] = x.wdata[8*b +: 8];
            exp_wr[sel]++;
        end else begin
            known = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (mdl.exists(base + b)) e.rdata[8*b +: 8] = mdl[base + b];
                else known = 1'b0;
            end
            e.chk = known;
            exp_rd[sel]++;
        end
        sb.push_back(e);
    endtask

    // Pipelined master: call and return at posedge+1; samples on the falling edge.
    task automatic run_xfers(input xfer_t xs [$], input string tag);
        int    idx = 0;
        int    cycles = 0;
        int    waits = 0;
        logic  dp_valid = 1'b0;
        xfer_t dp;
        exp_t  e;
        while (idx < xs.size() || dp_valid) begin
            if (idx < xs.size()) begin
                hsel = 1'b1; htrans = 2'b10; haddr = xs[idx].addr;
                hwrite = xs[idx].wr; hsize = xs[idx].size;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            hwdata = (dp_valid && dp.wr) ? dp.wdata : 32'h0;
            @(negedge clk);
            if (dp_valid) begin
                if (hready_bus) begin
                    e = sb.pop_front();
                    checks++;
                    if (waits !== e.waits) begin
                        failures++;
                        $display("FAIL %s waits @%h: got %0d expected %0d", tag, dp.addr, waits, e.waits);
                    end
                    checks++;
                    if (hresp_w[sel] !== e.err) begin
                        failures++;
                        $display("FAIL %s hresp @%h: got %b expected %b", tag, dp.addr, hresp_w[sel], e.err);
                    end
                    if (!e.wr && !e.err && e.chk) begin
                        checks++;
                        if (hrdata_w[sel] !== e.rdata) begin
                            failures++;
                            $display("FAIL %s hrdata @%h: got %h expected %h", tag, dp.addr,
                                     hrdata_w[sel], e.rdata);
                        end
                    end
                    dp_valid = 1'b0;
                end else begin
                    waits++;
                    checks++;
                    if (hresp_w[sel] !== sb[0].err) begin
                        failures++;
                        $display("FAIL %s hresp(wait) @%h: got %b expected %b", tag, dp.addr,
                                 hresp_w[sel], sb[0].err);
                    end
                end
            end
            if (hready_bus && idx < xs.size()) begin
                push_expected(xs[idx]);
                dp = xs[idx]; dp_valid = 1'b1; waits = 0; idx++;
            end
            @(posedge clk); #1;
            cycles++;
            if (cycles > 300) begin
                failures++;
                $display("FAIL %s timeout: got %0d cycles expected completion", tag, cycles);
                break;
            end
        end
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hready_w[k] !== 1'b1 || hresp_w[k] !== 1'b0 || hrdata_w[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset bus[%0d]: got rdy=%b resp=%b rdata=%h expected 1 0 0", k,
                         hready_w[k], hresp_w[k], hrdata_w[k]);
            end
            checks++;
            if (rd_w[k] !== 32'd0 || wr_w[k] !== 32'd0 || err_w[k] !== 32'd0) begin
                failures++;
                $display("FAIL reset cnt[%0d]: got %0d/%0d/%0d expected 0/0/0", k, rd_w[k],
                         wr_w[k], err_w[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        xfer_t xs [$];
        sel = 2'd0;
        xs.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        xs.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        for (int i = 0; i < 4; i++) xs.push_back(mk(1'b1, 32'h80 + 4 * i, 3'd2, $urandom()));
        for (int i = 0; i < 4; i++) xs.push_back(mk(1'b0, 32'h80 + 4 * i, 3'd2, 32'h0));
        run_xfers(xs, "b2b");
        checks++;
        if (wr_w[0] !== 32'(exp_wr[0]) || rd_w[0] !== 32'(exp_rd[0])) begin
            failures++;
            $display("FAIL b2b counters: got wr=%0d rd=%0d expected wr=%0d rd=%0d", wr_w[0],
                     rd_w[0], exp_wr[0], exp_rd[0]);
        end
    endtask

    task automatic test_wait_states();
        xfer_t xs [$];
        sel = 2'd1;
        xs.push_back(mk(1'b1, 32'h30, 3'd2, 32'hA5A5_0F0F));
        xs.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0));
        xs.push_back(mk(1'b0, 32'h30, 3'd2, 32'h0));
        run_xfers(xs, "wait3");
        checks++;
        if (rd_w[1] !== 32'd2 || wr_w[1] !== 32'd1) begin
            failures++;
            $display("FAIL wait3 counters: got rd=%0d wr=%0d expected rd=2 wr=1", rd_w[1], wr_w[1]);
        end
    endtask

    task automatic test_byte_lanes();
        xfer_t xs [$];
        sel = 2'd0;
        xs.push_back(mk(1'b1, 32'h20, 3'd2, 32'h0));
        xs.push_back(mk(1'b1, 32'h21, 3'd0, {4{8'hAA}}));
        xs.push_back(mk(1'b1, 32'h22, 3'd1, {2{16'h1234}}));
        xs.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
        xs.push_back(mk(1'b1, 32'h24, 3'd2, 32'h5555_6666));
        run_xfers(xs, "lanes");
        // hrdata must keep the last read word through the trailing write and idle.
        checks++;
        if (hrdata_w[0] !== 32'h1234AA00) begin
            failures++;
            $display("FAIL lanes hold: got %h expected %h", hrdata_w[0], 32'h1234AA00);
        end
    endtask

    task automatic test_err_window();
        xfer_t xs [$];
        sel = 2'd0;
        xs.push_back(mk(1'b1, 32'h104, 3'd2, 32'hCAFE_F00D));
        run_xfers(xs, "errwin");
        checks++;
        if (err_w[0] !== 32'd1) begin
            failures++;
            $display("FAIL errwin err_cnt: got %0d expected 1", err_w[0]);
        end
        xs = {};
        xs.push_back(mk(1'b1, 32'h0FC, 3'd2, 32'h0BAD_CAFE));
        xs.push_back(mk(1'b1, 32'h110, 3'd2, 32'h7777_8888));
        xs.push_back(mk(1'b0, 32'h104, 3'd2, 32'h0));
        xs.push_back(mk(1'b0, 32'h0FC, 3'd2, 32'h0));
        xs.push_back(mk(1'b0, 32'h110, 3'd2, 32'h0));
        run_xfers(xs, "errwin_edges");
        checks++;
        if (err_w[0] !== 32'd2) begin
            failures++;
            $display("FAIL errwin err_cnt2: got %0d expected 2", err_w[0]);
        end
    endtask

    task automatic test_illegal();
        xfer_t xs [$];
        int    base_err;
        sel = 2'd0;
        base_err = exp_err[0];
        xs.push_back(mk(1'b1, 32'h8, 3'd3, 32'h1111_1111));
        xs.push_back(mk(1'b1, 32'h3, 3'd1, 32'h2222_2222));
        xs.push_back(mk(1'b1, MemDepth * 4, 3'd2, 32'h3333_3333));
        xs.push_back(mk(1'b1, MemDepth * 4 - 4, 3'd2, 32'h4444_4444));
        xs.push_back(mk(1'b0, MemDepth * 4 - 4, 3'd2, 32'h0));
        run_xfers(xs, "illegal");
        checks++;
        if (err_w[0] !== 32'(base_err + 3)) begin
            failures++;
            $display("FAIL illegal err_cnt: got %0d expected %0d", err_w[0], base_err + 3);
        end
    endtask

    task automatic test_reset_mid();
        xfer_t xs [$];
        sel = 2'd2;
        xs.push_back(mk(1'b1, 32'h40, 3'd2, 32'h1111_2222));
        run_xfers(xs, "rst_pre");
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBAD0_BAD0;
        checks++;
        if (hready_w[2] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid wait1 hready: got %b expected 0", hready_w[2]);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hready_w[2] !== 1'b1 || hresp_w[2] !== 1'b0 || hrdata_w[2] !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid bus: got rdy=%b resp=%b rdata=%h expected 1 0 0", hready_w[2],
                     hresp_w[2], hrdata_w[2]);
        end
        checks++;
        if (rd_w[2] !== 32'd0 || wr_w[2] !== 32'd0 || err_w[2] !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid cnt: got %0d/%0d/%0d expected 0/0/0", rd_w[2], wr_w[2], err_w[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 0; exp_wr[k] = 0; exp_err[k] = 0;
        end
        @(posedge clk); #1;
        xs = {};
        xs.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
        run_xfers(xs, "rst_post");
        checks++;
        if (hrdata_w[2] !== 32'h1111_2222 || rd_w[2] !== 32'd1 || wr_w[2] !== 32'd0) begin
            failures++;
            $display("FAIL rst_post: got rdata=%h rd=%0d wr=%0d expected 11112222 1 0",
                     hrdata_w[2], rd_w[2], wr_w[2]);
        end
    endtask

    initial begin
        rst_n = 1'b1; hsel = 1'b0; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0;
        hsize = 3'd2; htrans = 2'b00; sel = 2'd0;
        for (int k = 0; k < 3; k++) begin
            exp_rd[k] = 0; exp_wr[k] = 0; exp_err[k] = 0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_err_window();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
